// File: rtl/sdrc_rd_width_packer.sv
// Read-side width packer: gathers 8/16-bit SDRAM read beats into 32-bit
// application words, one-cycle valid strobe, burst-last and partial-word error.
module sdrc_rd_width_packer #(
    parameter int APP_DW = 32,
    parameter int SDR_DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        sdr_width,
    input  logic              x2a_rdstart,
    input  logic              x2a_rdok,
    input  logic              x2a_rdlast,
    input  logic [SDR_DW-1:0] x2a_rddt,
    output logic              app_rd_valid,
    output logic [APP_DW-1:0] app_rd_data,
    output logic              app_rd_last,
    output logic              app_rd_err,
    output logic [1:0]        rd_xfr_count
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        width_q;     // width sampled at burst start
    logic [1:0]        width_eff;   // width governing the current beat
    logic [1:0]        k;           // slot of the current beat in the word
    logic [1:0]        last_k;      // final slot index (N-1)
    logic [1:0]        cnt_nxt;
    logic [APP_DW-1:0] saved;       // lower slots collected so far
    logic [APP_DW-1:0] base;
    logic [APP_DW-1:0] beat_pos;
    logic [APP_DW-1:0] merged;
    logic              first;
    logic              word_done;
    logic              partial;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, beat placement and word-completion decode
    always_comb begin
        state_nxt = state;
        first     = x2a_rdok & x2a_rdstart;
        width_eff = first ? sdr_width : width_q;
        // A start beat (even mid-word) always opens a fresh word in slot 0
        k         = (first || state == IDLE) ? 2'd0 : rd_xfr_count;
        base      = (first || state == IDLE) ? '0 : saved;
        case (width_eff)
            2'b00: begin
                last_k   = 2'd0;
                beat_pos = APP_DW'(x2a_rddt);
            end
            2'b01: begin
                last_k   = 2'd1;
                beat_pos = APP_DW'(x2a_rddt[15:0]) << {k[0], 4'b0000};
            end
            default: begin
                last_k   = 2'd3;
                beat_pos = APP_DW'(x2a_rddt[7:0]) << {k, 3'b000};
            end
        endcase
        // Slots above a partial word stay zero because saved is cleared per word
        merged    = base | beat_pos;
        word_done = x2a_rdok & ((k == last_k) | x2a_rdlast);
        partial   = x2a_rdok & x2a_rdlast & (k != last_k);
        cnt_nxt   = word_done ? 2'd0 : k + 2'd1;
        if (x2a_rdok) state_nxt = word_done ? IDLE : COLLECT;
    end

    // Datapath: accumulation, output word, strobe and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            app_rd_valid <= 1'b0;
            app_rd_last  <= 1'b0;
            app_rd_err   <= 1'b0;
            app_rd_data  <= '0;
            rd_xfr_count <= 2'd0;
            saved        <= '0;
            width_q      <= 2'b00;
        end else begin
            app_rd_valid <= word_done;
            app_rd_last  <= word_done & x2a_rdlast;
            if (first) width_q <= sdr_width;
            if (x2a_rdok) begin
                rd_xfr_count <= cnt_nxt;
                saved        <= word_done ? '0 : merged;
            end
            if (word_done) app_rd_data <= merged;
            if (partial)    app_rd_err <= 1'b1;
            else if (first) app_rd_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdrc_rd_width_packer.sv
// Randomized and directed bench for sdrc_rd_width_packer against a burst-level
// model that groups beats into words arithmetically.
module tb_sdrc_rd_width_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sdr_width;
    logic        x2a_rdstart, x2a_rdok, x2a_rdlast;
    logic [15:0] x2a_rddt;
    logic        app_rd_valid, app_rd_last, app_rd_err;
    logic [31:0] app_rd_data;
    logic [1:0]  rd_xfr_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [1:0]  exp_cnt;
    logic [15:0] bdata [16];

    sdrc_rd_width_packer #(.APP_DW(32), .SDR_DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sdr_width    (sdr_width),
        .x2a_rdstart  (x2a_rdstart),
        .x2a_rdok     (x2a_rdok),
        .x2a_rdlast   (x2a_rdlast),
        .x2a_rddt     (x2a_rddt),
        .app_rd_valid (app_rd_valid),
        .app_rd_data  (app_rd_data),
        .app_rd_last  (app_rd_last),
        .app_rd_err   (app_rd_err),
        .rd_xfr_count (rd_xfr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one burst of n beats at width w. with_last=0 leaves the burst open
    // (the next burst's start abandons it). gap_len idle cycles follow beat
    // gap_at; rnd adds random 0..2 idle cycles after every beat. From beat
    // chg_at+1 on, sdr_width is driven to 8-bit (must be ignored).
    task automatic run_burst(input logic [1:0] w, input int n, input bit with_last,
                             input int gap_at, input int gap_len, input bit rnd,
                             input int chg_at);
        int          nb, bits, pos, g;
        logic [31:0] acc, val, mask;
        bit          done, lst;
        nb   = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        bits = (nb == 4) ? 8 : 16;
        mask = (nb == 4) ? 32'h0000_00FF : 32'h0000_FFFF;
        acc  = 0;
        for (int i = 0; i < n; i++) begin
            lst         = with_last && (i == n - 1);
            x2a_rdstart = (i == 0);
            x2a_rdok    = 1'b1;
            x2a_rdlast  = lst;
            x2a_rddt    = bdata[i];
            sdr_width   = (chg_at >= 0 && i > chg_at) ? 2'b10 : w;
            pos  = i % nb;
            val  = 32'(bdata[i]) & mask;
            acc  = acc + (val << (bits * pos));
            done = (pos == nb - 1) || lst;
            if (i == 0) exp_err = 1'b0;
            if (done && lst && pos != nb - 1) exp_err = 1'b1;
            exp_cnt = done ? 2'd0 : 2'(pos + 1);
            @(posedge clk); #1;
            x2a_rdstart = 1'b0;
            x2a_rdok    = 1'b0;
            x2a_rdlast  = 1'b0;
            chk("valid", 32'(app_rd_valid), 32'(done));
            if (done) begin
                chk("data", app_rd_data, acc);
                chk("last", 32'(app_rd_last), 32'(lst));
                exp_data = acc;
                acc = 0;
            end
            chk("count", 32'(rd_xfr_count), 32'(exp_cnt));
            chk("err", 32'(app_rd_err), 32'(exp_err));
            g = (i == gap_at) ? gap_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int j = 0; j < g; j++) begin
                x2a_rdlast = 1'($urandom);
                x2a_rddt   = 16'($urandom);
                sdr_width  = 2'($urandom);
                @(posedge clk); #1;
                chk("gap_valid", 32'(app_rd_valid), 32'd0);
                chk("gap_data", app_rd_data, exp_data);
                chk("gap_count", 32'(rd_xfr_count), 32'(exp_cnt));
                chk("gap_err", 32'(app_rd_err), 32'(exp_err));
            end
            x2a_rdlast = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(app_rd_valid), 32'd0);
        chk({tag, "_last"},  32'(app_rd_last),  32'd0);
        chk({tag, "_err"},   32'(app_rd_err),   32'd0);
        chk({tag, "_count"}, 32'(rd_xfr_count), 32'd0);
        chk({tag, "_data"},  app_rd_data,       32'd0);
    endtask

    initial begin
        reset = 1'b1; sdr_width = 2'b00;
        x2a_rdstart = 1'b0; x2a_rdok = 1'b0; x2a_rdlast = 1'b0; x2a_rddt = '0;
        exp_data = 0; exp_err = 1'b0; exp_cnt = 2'd0;
        #12;
        chk_reset_state("rst");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // T1: 16-bit two beats
        bdata[0] = 16'h1111; bdata[1] = 16'h2222;
        run_burst(2'b01, 2, 1, -1, 0, 0, -1);
        // T2: 8-bit four beats, 2-cycle gap after 2nd
        bdata[0] = 16'h55A1; bdata[1] = 16'h66B2; bdata[2] = 16'h77C3; bdata[3] = 16'h88D4;
        run_burst(2'b10, 4, 1, 1, 2, 0, -1);
        chk("t2_word", exp_data, 32'hD4C3B2A1);
        // T3: 32-bit three beats
        bdata[0] = 16'hAAAA; bdata[1] = 16'hBBBB; bdata[2] = 16'hCCCC;
        run_burst(2'b00, 3, 1, -1, 0, 0, -1);
        // T4: 8-bit partial word sets err; next start clears it
        bdata[0] = 16'h0011; bdata[1] = 16'h0022;
        run_burst(2'b11, 2, 1, -1, 0, 0, -1);
        chk("t4_err", 32'(app_rd_err), 32'd1);
        bdata[0] = 16'h1234; bdata[1] = 16'h5678;
        run_burst(2'b01, 2, 1, -1, 0, 0, -1);
        // T5: 16-bit four beats, sdr_width moved to 8-bit after beat 1
        bdata[0] = 16'hA0A0; bdata[1] = 16'hB1B1; bdata[2] = 16'hC2C2; bdata[3] = 16'hD3D3;
        run_burst(2'b01, 4, 1, -1, 0, 0, 0);
        // Abandon mid-word via new start, then a fresh burst
        bdata[0] = 16'h00EE; bdata[1] = 16'h00FF;
        run_burst(2'b10, 2, 0, -1, 0, 0, -1);
        bdata[0] = 16'h0101; bdata[1] = 16'h0202;
        run_burst(2'b01, 2, 1, -1, 0, 0, -1);
        // T6: 8-bit, reset after 3rd beat
        bdata[0] = 16'h0031; bdata[1] = 16'h0032; bdata[2] = 16'h0033;
        run_burst(2'b10, 3, 0, -1, 0, 0, -1);
        reset = 1'b1; #2;
        chk_reset_state("t6");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_data = 0; exp_err = 1'b0; exp_cnt = 2'd0;
        @(posedge clk); #1;
        chk_reset_state("t6_post");
        bdata[0] = 16'h0041; bdata[1] = 16'h0042; bdata[2] = 16'h0043; bdata[3] = 16'h0044;
        run_burst(2'b10, 4, 1, -1, 0, 0, -1);

        // Randomized bursts
        for (int t = 0; t < 200; t++) begin
            logic [1:0] w;
            int         n;
            bit         wl;
            w  = 2'($urandom);
            n  = int'($urandom_range(1, 12));
            wl = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < n; i++) bdata[i] = 16'($urandom);
            run_burst(w, n, wl, -1, 0, 1, ($urandom_range(0, 3) == 0) ? 0 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
